// File: rtl/frame_deserializer.sv
// Multi-lane serial-to-parallel frame deserializer with HUNT/SYNC/LOCKED framing.
// Define FRAME_DESER_ERRCNT_EN to build the saturating frame error counter.
module frame_deserializer #(
   parameter int FRAME_BITS  = 256,
   parameter int LANES       = 2,
   parameter int LOCK_FRAMES = 2,
   parameter int UNLOCK_ERRS = 3
) (
   input  logic                        sclk,
   input  logic                        rstn,
   input  logic [LANES-1:0]            sdata,
   input  logic                        sfs,
   input  logic                        err_clr,
   output logic                        pvalid,
   output logic [LANES*FRAME_BITS-1:0] pdata,
   output logic                        locked,
   output logic                        frame_err,
   output logic [15:0]                 err_count
);

   localparam int BW = $clog2(FRAME_BITS);
   localparam int GW = $clog2(LOCK_FRAMES + 1);
   localparam int MW = $clog2(UNLOCK_ERRS + 1);
   localparam logic [BW-1:0] BC_LAST = BW'(FRAME_BITS - 1);
   localparam logic [GW-1:0] GOOD_N  = GW'(LOCK_FRAMES);
   localparam logic [MW-1:0] MISS_N  = MW'(UNLOCK_ERRS);

   typedef enum logic [1:0] {
      HUNT,
      SYNC,
      LOCKED
   } state_t;

   state_t state, state_n;

   logic [BW-1:0] bc, bc_n;
   logic [GW-1:0] good, good_n;
   logic [MW-1:0] miss, miss_n;
   logic          take, ferr_n;
   logic          at_end, good_fr, bad_fr;

   // Only FRAME_BITS-1 history bits are kept; the current sdata bit completes the frame.
   logic [FRAME_BITS-2:0]       sh [LANES];
   logic [LANES*FRAME_BITS-1:0] frame;

   always_comb begin
      frame = '0;
      for (int i = 0; i < LANES; i++)
         frame[i*FRAME_BITS +: FRAME_BITS] = {sh[i], sdata[i]};
   end

   assign at_end  = (bc == BC_LAST);
   assign good_fr = sfs & at_end;
   assign bad_fr  = sfs ^ at_end;

   always_comb begin
      state_n = state;
      bc_n    = at_end ? '0 : bc + BW'(1);
      good_n  = good;
      miss_n  = miss;
      take    = 1'b0;
      ferr_n  = 1'b0;
      unique case (state)
         HUNT: begin
            bc_n = '0;
            if (sfs)
               state_n = SYNC;
         end
         SYNC: begin
            if (sfs)
               bc_n = '0;
            if (good_fr) begin
               good_n = good + GW'(1);
               if (good + GW'(1) == GOOD_N) begin
                  state_n = LOCKED;
                  take    = 1'b1;
               end
            end else if (bad_fr) begin
               good_n = '0;
               ferr_n = 1'b1;
            end
         end
         LOCKED: begin
            if (sfs)
               bc_n = '0;
            if (good_fr) begin
               miss_n = '0;
               take   = 1'b1;
            end else if (bad_fr) begin
               ferr_n = 1'b1;
               if (miss + MW'(1) == MISS_N) begin
                  state_n = HUNT;
                  bc_n    = '0;
                  good_n  = '0;
                  miss_n  = '0;
               end else begin
                  miss_n = miss + MW'(1);
               end
            end
         end
         default: state_n = HUNT;
      endcase
   end

   always_ff @(posedge sclk) begin
      if (!rstn) begin
         state     <= HUNT;
         bc        <= '0;
         good      <= '0;
         miss      <= '0;
         pvalid    <= 1'b0;
         pdata     <= '0;
         locked    <= 1'b0;
         frame_err <= 1'b0;
         for (int i = 0; i < LANES; i++)
            sh[i] <= '0;
      end else begin
         state     <= state_n;
         bc        <= bc_n;
         good      <= good_n;
         miss      <= miss_n;
         pvalid    <= take;
         locked    <= (state_n == LOCKED);
         frame_err <= ferr_n;
         if (take)
            pdata <= frame;
         for (int i = 0; i < LANES; i++)
            sh[i] <= frame[i*FRAME_BITS +: FRAME_BITS-1];
      end
   end

`ifdef FRAME_DESER_ERRCNT_EN
   // Clear wins over a coincident error so software sees a clean zero.
   always_ff @(posedge sclk) begin
      if (!rstn)
         err_count <= '0;
      else if (err_clr)
         err_count <= '0;
      else if (frame_err && err_count != 16'hFFFF)
         err_count <= err_count + 16'd1;
   end
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign err_count      = '0;
`endif

endmodule
